// File: rtl/board_line_clear.sv
// Fallen-block board: merges a landed piece, then scans bottom-up and removes full rows.
// Reports rows cleared per lock and a saturating running total.
module board_line_clear #(
    parameter int BLOCKS_WIDE  = 10,
    parameter int BLOCKS_HIGH  = 22,
    parameter int BITS_BLK_POS = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              lock_valid,
    output logic                              lock_ready,
    input  logic [BITS_BLK_POS-1:0]           blk_1,
    input  logic [BITS_BLK_POS-1:0]           blk_2,
    input  logic [BITS_BLK_POS-1:0]           blk_3,
    input  logic [BITS_BLK_POS-1:0]           blk_4,
    output logic [BLOCKS_WIDE*BLOCKS_HIGH-1:0] fallen_pieces,
    output logic                              busy,
    output logic                              done,
    output logic [2:0]                        lines_cleared,
    output logic [15:0]                       total_lines
);
    localparam int CELLS = BLOCKS_WIDE * BLOCKS_HIGH;
    localparam int ROW_W = $clog2(BLOCKS_HIGH);

    typedef enum logic [2:0] {IDLE, MERGE, SCAN, SHIFT, DONE} state_t;

    state_t                  state;
    logic [BLOCKS_WIDE-1:0]  rows [BLOCKS_HIGH];
    logic [BITS_BLK_POS-1:0] blk_q [4];
    logic [ROW_W-1:0]        scan_row;
    logic [ROW_W-1:0]        shift_row;
    logic [2:0]              line_cnt;
    logic [CELLS-1:0]        merge_mask;
    logic [16:0]             total_sum;

    assign busy       = (state != IDLE);
    assign lock_ready = (state == IDLE);
    assign done       = (state == DONE);

    always_comb begin
        fallen_pieces = '0;
        for (int unsigned y = 0; y < BLOCKS_HIGH; y++)
            fallen_pieces[y*BLOCKS_WIDE +: BLOCKS_WIDE] = rows[y];
    end

    // Off-board indices simply never reach the mask
    always_comb begin
        merge_mask = '0;
        for (int unsigned i = 0; i < 4; i++)
            if (32'(blk_q[i]) < 32'(CELLS))
                merge_mask[blk_q[i]] = 1'b1;
    end

    assign total_sum = {1'b0, total_lines} + 17'(line_cnt);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            scan_row      <= '0;
            shift_row     <= '0;
            line_cnt      <= '0;
            lines_cleared <= '0;
            total_lines   <= '0;
            for (int unsigned y = 0; y < BLOCKS_HIGH; y++)
                rows[y] <= '0;
            for (int unsigned i = 0; i < 4; i++)
                blk_q[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (lock_valid) begin
                        blk_q[0] <= blk_1;
                        blk_q[1] <= blk_2;
                        blk_q[2] <= blk_3;
                        blk_q[3] <= blk_4;
                        line_cnt <= '0;
                        state    <= MERGE;
                    end
                end
                MERGE: begin
                    for (int unsigned y = 0; y < BLOCKS_HIGH; y++)
                        rows[y] <= rows[y] | merge_mask[y*BLOCKS_WIDE +: BLOCKS_WIDE];
                    scan_row <= ROW_W'(BLOCKS_HIGH - 1);
                    state    <= SCAN;
                end
                SCAN: begin
                    if (&rows[scan_row]) begin
                        line_cnt  <= line_cnt + 3'd1;
                        shift_row <= scan_row;
                        state     <= SHIFT;
                    end else if (scan_row == '0) begin
                        // Results are registered on entry so they are valid while done is high
                        lines_cleared <= line_cnt;
                        total_lines   <= total_sum[16] ? 16'hFFFF : total_sum[15:0];
                        state         <= DONE;
                    end else begin
                        scan_row <= scan_row - ROW_W'(1);
                    end
                end
                SHIFT: begin
                    if (shift_row != '0) begin
                        rows[shift_row] <= rows[shift_row - ROW_W'(1)];
                        shift_row       <= shift_row - ROW_W'(1);
                    end else begin
                        rows[0] <= '0;
                        state   <= SCAN;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_board_line_clear.sv
// Scoreboard bench for board_line_clear: expected board/count/latency pushed at accept,
// compared when done pulses.
module tb_board_line_clear;
    localparam int W = 10;
    localparam int H = 22;
    localparam int N = W * H;

    typedef struct {
        logic [N-1:0] board;
        int           lines;
        int           total;
        int           lat;
        int           acc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         lock_valid;
    logic         lock_ready;
    logic [7:0]   blk_1, blk_2, blk_3, blk_4;
    logic [N-1:0] fallen_pieces;
    logic         busy, done;
    logic [2:0]   lines_cleared;
    logic [15:0]  total_lines;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int last_done_cyc = 0;
    int last_acc = 0;
    exp_t sb[$];
    logic [N-1:0] model_board = '0;
    int model_total = 0;

    board_line_clear #(.BLOCKS_WIDE(W), .BLOCKS_HIGH(H), .BITS_BLK_POS(8)) dut (
        .clk(clk), .rst(rst), .lock_valid(lock_valid), .lock_ready(lock_ready),
        .blk_1(blk_1), .blk_2(blk_2), .blk_3(blk_3), .blk_4(blk_4),
        .fallen_pieces(fallen_pieces), .busy(busy), .done(done),
        .lines_cleared(lines_cleared), .total_lines(total_lines)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Independent reference: non-full rows compact to the bottom; the k-th full row from
    // the bottom (original row y) sits at row y+k when removed, costing y+k+2 cycles.
    task automatic model_lock(input int p1, input int p2, input int p3, input int p4,
                              output exp_t e);
        logic [N-1:0] b;
        logic [W-1:0] row;
        int dst, lines, lat;
        int p[4];
        p = '{p1, p2, p3, p4};
        b = model_board;
        foreach (p[i]) if (p[i] < N) b[p[i]] = 1'b1;
        e.board = '0;
        dst = H - 1;
        lines = 0;
        lat = H + 1;
        for (int y = H - 1; y >= 0; y--) begin
            row = b[y*W +: W];
            if (&row) begin
                lat += y + lines + 2;
                lines++;
            end else begin
                e.board[dst*W +: W] = row;
                dst--;
            end
        end
        model_total = (model_total + lines > 65535) ? 65535 : model_total + lines;
        model_board = e.board;
        e.lines = lines;
        e.total = model_total;
        e.lat = lat;
    endtask

    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            last_done_cyc = cyc;
            if (sb.size() == 0) begin
                check("spurious_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                last_acc = e.acc;
                check("lines_cleared", lines_cleared, e.lines);
                check("total_lines", total_lines, e.total);
                check("board", fallen_pieces, e.board);
                check("latency", cyc - e.acc, e.lat);
            end
        end
    end

    task automatic wait_done(input int start);
        int n = 0;
        while (done_cnt == start && n < 400) begin
            tick();
            n++;
        end
        if (done_cnt == start) check("done_timeout", 0, 1);
    endtask

    task automatic do_lock(input int p1, input int p2, input int p3, input int p4,
                           input bit wait_for_done);
        exp_t e;
        int n = 0;
        int start = done_cnt;
        blk_1 = 8'(p1); blk_2 = 8'(p2); blk_3 = 8'(p3); blk_4 = 8'(p4);
        lock_valid = 1'b1;
        while (!lock_ready && n < 400) begin
            tick();
            n++;
        end
        if (!lock_ready) begin
            check("ready_timeout", 0, 1);
            lock_valid = 1'b0;
            return;
        end
        model_lock(p1, p2, p3, p4, e);
        e.acc = cyc + 1;
        sb.push_back(e);
        tick();
        lock_valid = 1'b0;
        if (wait_for_done) wait_done(start);
    endtask

    initial begin
        logic [N-1:0] m;
        int cells[$];
        int d0;

        rst = 1'b1; lock_valid = 1'b0;
        blk_1 = '0; blk_2 = '0; blk_3 = '0; blk_4 = '0;
        tick();
        check("rst_done0", done, 0);
        tick();
        check("rst_done1", done, 0);
        rst = 1'b0;
        check("rst_board", fallen_pieces, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", lock_ready, 1);
        check("rst_total", total_lines, 0);
        check("rst_lines", lines_cleared, 0);

        // Simple lock: merge visible two edges after accept, done 23 edges after accept
        d0 = done_cnt;
        do_lock(210, 211, 212, 213, 1'b0);
        check("merge_pending", fallen_pieces, 0);
        tick();
        m = '0; m[213:210] = 4'hF;
        check("merge_bits", fallen_pieces, m);
        check("busy_scan", busy, 1);
        check("ready_scan", lock_ready, 0);
        wait_done(d0);
        check("simple_latency", last_done_cyc - last_acc, 23);
        tick();
        check("ready_after", lock_ready, 1);
        check("done_one_cycle", done, 0);

        // Single clear of row 21 with one cell above in row 20
        do_lock(214, 215, 200, 200, 1'b1);
        do_lock(216, 217, 218, 219, 1'b1);
        check("single_latency", last_done_cyc - last_acc, 46);
        m = '0; m[210] = 1'b1;
        check("single_board", fallen_pieces, m);
        check("single_total", total_lines, 1);
        repeat (5) tick();
        check("lines_held", lines_cleared, 1);

        // Four-row clear
        for (int y = 18; y <= 21; y++)
            for (int x = 0; x < 9; x++) cells.push_back(y * W + x);
        while (cells.size() >= 4) begin
            do_lock(cells[0], cells[1], cells[2], cells[3], 1'b1);
            repeat (4) void'(cells.pop_front());
        end
        do_lock(189, 199, 209, 219, 1'b1);
        check("four_lines", lines_cleared, 4);
        check("four_total", total_lines, 5);
        check("four_board", fallen_pieces, 0);
        check("four_latency", last_done_cyc - last_acc, 115);

        // lock_valid during SCAN is ignored
        d0 = done_cnt;
        do_lock(0, 1, 2, 3, 1'b0);
        repeat (3) tick();
        blk_1 = 8'd100; blk_2 = 8'd101; blk_3 = 8'd102; blk_4 = 8'd103;
        lock_valid = 1'b1;
        repeat (2) tick();
        lock_valid = 1'b0;
        wait_done(d0);
        repeat (30) tick();
        check("ignored_done_once", done_cnt - d0, 1);
        check("ignored_board", fallen_pieces, 'hF);

        // Off-board index dropped
        do_lock(250, 4, 5, 6, 1'b1);
        check("oob_board", fallen_pieces, 'h7F);
        check("oob_total", total_lines, 5);

        // Reset during SHIFT
        do_lock(210, 211, 212, 213, 1'b1);
        do_lock(214, 215, 216, 217, 1'b1);
        d0 = done_cnt;
        do_lock(218, 219, 219, 219, 1'b0);
        repeat (4) tick();
        check("mid_busy", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        model_board = '0;
        model_total = 0;
        check("mid_board", fallen_pieces, 0);
        check("mid_ready", lock_ready, 1);
        check("mid_busy_clr", busy, 0);
        check("mid_total", total_lines, 0);
        repeat (40) tick();
        check("mid_no_done", done_cnt - d0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
